// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave: the unit's view; master: the pipeline/memory side driving it.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data_write;
    logic [31:0] mem_data_read;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_read,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_address, mem_data_write
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_read,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_address, mem_data_write
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time towards a big-endian word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are extracted and extended here.
module lsu_ctrl #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input logic      clk,
    input logic      rst_n,
    lsu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  nbytes_m1;
    logic [33:0] last_byte;
    logic [31:0] load_value;
    logic [31:0] store_word;

    // Byte/half lane selection and extension; big-endian so offset 0 is bits [31:24].
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        res = word;
        b   = 8'h00;
        h   = 16'h0000;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    b = word[31:24];
                    2'd1:    b = word[23:16];
                    2'd2:    b = word[15:8];
                    default: b = word[7:0];
                endcase
                res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h   = off[1] ? word[15:0] : word[31:16];
                res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of the previously read word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    res[31:24] = wdata[7:0];
                    2'd1:    res[23:16] = wdata[7:0];
                    2'd2:    res[15:8]  = wdata[7:0];
                    default: res[7:0]   = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res[15:0] = wdata[15:0];
                end else begin
                    res[31:16] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Request decode: error detection uses 34-bit arithmetic so the range check never wraps.
    always_comb begin
        accept = bus.req_valid && (state_q == StIdle);
        case (bus.req_size)
            2'b00:   nbytes_m1 = 2'd0;
            2'b01:   nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase
        last_byte = {2'b00, bus.req_addr} + {32'h0000_0000, nbytes_m1};
        req_err   = (bus.req_size == 2'b11)
                 || ((bus.req_size == 2'b01) && bus.req_addr[0])
                 || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                 || (last_byte >= 34'(MEM_DEPTH));
        load_value = load_extract(bus.mem_data_read, size_q, unsigned_q, addr_q[1:0]);
        store_word = store_merge(rword_q, wdata_q, size_q, addr_q[1:0]);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!bus.req_store) begin
                        state_d = StRd;
                    end else if (bus.req_size == 2'b10) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = store_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, read-word capture and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            rword_q      <= 32'h0000_0000;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                store_q    <= bus.req_store;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                if (req_err) begin
                    resp_rdata_q <= 32'h0000_0000;
                    resp_err_q   <= 1'b1;
                end
            end
            if (state_q == StRd) begin
                rword_q <= bus.mem_data_read;
                if (!store_q) begin
                    resp_rdata_q <= load_value;
                    resp_err_q   <= 1'b0;
                end
            end
            if (state_q == StWr) begin
                resp_rdata_q <= 32'h0000_0000;
                resp_err_q   <= 1'b0;
            end
        end
    end

    // Outputs decoded from registered state only; reset drops mem_write at once.
    always_comb begin
        bus.req_ready      = (state_q == StIdle);
        bus.resp_valid     = (state_q == StResp);
        bus.resp_rdata     = resp_rdata_q;
        bus.resp_err       = resp_err_q;
        bus.mem_read       = (state_q == StRd);
        bus.mem_write      = (state_q == StWr);
        bus.mem_address    = {addr_q[31:2], 2'b00};
        bus.mem_data_write = (state_q == StWr) ? store_word : 32'h0000_0000;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural big-endian word memory.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
        logic [31:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   nvec;
    int   nmis;
    int   nrd;
    int   nwr;
    exp_t sb[$];
    logic [31:0] dm [0:255];

    lsu_ctrl_if bus ();

    lsu_ctrl #(
        .MEM_DEPTH(1024)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Data memory: read data appears on the negedge inside the read cycle, writes on posedge.
    initial begin
        bus.mem_data_read = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_read) bus.mem_data_read = dm[bus.mem_address[9:2]];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (bus.mem_write) dm[bus.mem_address[9:2]] = bus.mem_data_write;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts memory strobes per request and checks each response against the queue.
    initial begin
        exp_t e;
        nrd = 0;
        nwr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrd = 0;
                nwr = 0;
            end else begin
                if (bus.mem_read || bus.mem_write)
                    chk("mem_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
                if (bus.mem_read) begin
                    nrd++;
                    if (sb.size() != 0) chk("rd_addr", bus.mem_address, sb[0].addr);
                end
                if (bus.mem_write) begin
                    nwr++;
                    if (sb.size() != 0) begin
                        chk("wr_addr", bus.mem_address, sb[0].addr);
                        chk("wr_data", bus.mem_data_write, sb[0].wdata);
                    end
                end
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nmis++;
                        $display("FAIL unexpected_resp: got resp_valid=1, expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("resp_rdata", bus.resp_rdata, e.rdata);
                        chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
                        chk("latency", cyc, e.cyc);
                        chk("mem_read_cycles", nrd, e.nrd);
                        chk("mem_write_cycles", nwr, e.nwr);
                    end
                    nrd = 0;
                    nwr = 0;
                end
            end
        end
    end

    // Issue one request and push its expected response; hold keeps req_valid high afterwards.
    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int lat,
                        input int erdn, input int ewrn, input logic [31:0] ewd, input bit hold);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1 within 50 cycles");
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.rdata = erd;
            e.err   = eerr;
            e.cyc   = cyc + lat - 1;
            e.nrd   = erdn;
            e.nwr   = ewrn;
            e.wdata = ewd;
            e.addr  = {a[31:2], 2'b00};
            sb.push_back(e);
            chk("ready_low_after_accept", {31'h0, bus.req_ready}, 32'h0);
            // Scramble inputs after accept; the unit must ignore them.
            bus.req_addr  = a ^ 32'h0000_0044;
            bus.req_wdata = ~wd;
            bus.req_store = ~st;
            if (!hold) bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        for (int i = 0; i < 256; i++) dm[i] = 32'h0;
        dm[4]   = 32'h8899AABB;
        dm[8]   = 32'h55667788;
        dm[255] = 32'hCAFEF00D;
        bus.req_valid    = 1'b0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        chk("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
        chk("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
        chk("rst_mem_address", bus.mem_address, 32'h0);
        chk("rst_mem_data_write", bus.mem_data_write, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Loads: st sz uns addr wdata | rdata err lat nrd nwr wdata hold
        send(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 2, 1, 0, 0, 0);
        send(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFF99, 0, 2, 1, 0, 0, 0);
        send(0, 2'b00, 1, 32'h11, 0, 32'h00000099, 0, 2, 1, 0, 0, 0);
        send(0, 2'b01, 0, 32'h12, 0, 32'hFFFFAABB, 0, 2, 1, 0, 0, 0);
        send(0, 2'b01, 1, 32'h10, 0, 32'h00008899, 0, 2, 1, 0, 0, 0);
        // Sub-word stores as read-modify-write
        send(1, 2'b00, 0, 32'h12, 32'h000000CC, 0, 0, 3, 1, 1, 32'h8899CCBB, 0);
        send(0, 2'b10, 0, 32'h10, 0, 32'h8899CCBB, 0, 2, 1, 0, 0, 0);
        send(1, 2'b01, 0, 32'h10, 32'h00001234, 0, 0, 3, 1, 1, 32'h1234CCBB, 0);
        send(0, 2'b10, 0, 32'h10, 0, 32'h1234CCBB, 0, 2, 1, 0, 0, 0);
        // Errors: misaligned, illegal size, out of range, 32-bit wrap
        send(0, 2'b10, 0, 32'h13, 0, 0, 1, 1, 0, 0, 0, 0);
        send(1, 2'b01, 0, 32'h11, 32'h5555, 0, 1, 1, 0, 0, 0, 0);
        send(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0, 0, 0);
        send(0, 2'b10, 0, 32'h400, 0, 0, 1, 1, 0, 0, 0, 0);
        send(0, 2'b10, 0, 32'hFFFFFFFC, 0, 0, 1, 1, 0, 0, 0, 0);
        send(0, 2'b01, 0, 32'h3FF, 0, 0, 1, 1, 0, 0, 0, 0);
        // Top of memory boundary
        send(0, 2'b10, 0, 32'h3FC, 0, 32'hCAFEF00D, 0, 2, 1, 0, 0, 0);
        send(0, 2'b01, 0, 32'h3FE, 0, 32'hFFFFF00D, 0, 2, 1, 0, 0, 0);
        send(0, 2'b00, 1, 32'h3FF, 0, 32'h0000000D, 0, 2, 1, 0, 0, 0);
        // Back-to-back with req_valid held high
        send(1, 2'b10, 0, 32'h14, 32'h01020304, 0, 0, 2, 0, 1, 32'h01020304, 1);
        send(0, 2'b00, 1, 32'h17, 0, 32'h00000004, 0, 2, 1, 0, 0, 1);
        send(0, 2'b00, 0, 32'h14, 0, 32'h00000001, 0, 2, 1, 0, 0, 1);
        send(1, 2'b00, 0, 32'h15, 32'h000000AA, 0, 0, 3, 1, 1, 32'h01AA0304, 1);
        send(0, 2'b01, 1, 32'h16, 0, 32'h00000304, 0, 2, 1, 0, 0, 0);
        drain();
        chk("dm_word_14", dm[5], 32'h01AA0304);

        // Reset in the middle of a word-store write cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_store = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wr_before_reset", {31'h0, bus.mem_write}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wr_drop_on_reset", {31'h0, bus.mem_write}, 32'h0);
        chk("rd_on_reset", {31'h0, bus.mem_read}, 32'h0);
        chk("resp_valid_on_reset", {31'h0, bus.resp_valid}, 32'h0);
        chk("resp_rdata_on_reset", bus.resp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("dm_word_20_kept", dm[8], 32'h55667788);
        chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
        chk("no_pending", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the data-memory interface. It sits between the MEM pipeline stage and the DM word port.
- Takes one load/store request at a time and drives the DM signals mem_read, mem_write, address and data_write. It then captures data_read.
- Sub-word stores are done as read-modify-write, since DM writes only whole 4-byte words. Sub-word loads are extracted and sign- or zero-extended here.
- Memory is big-endian: the byte at word address A+0 is data bits [31:24].

Parameters:
- MEM_DEPTH, 1024: DM size in bytes. Any access whose last byte is at or beyond MEM_DEPTH is a range error.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on a posedge where req_valid && req_ready
- req_store  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse at completion
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size or out of range
- mem_read  out  1  to DM
- mem_write  out  1  to DM
- mem_address  out  32  to DM; always word aligned, {addr[31:2],2'b00}
- mem_data_write  out  32  to DM
- mem_data_read  in  32  from DM; valid at the posedge ending a mem_read cycle

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_address=0; mem_data_write=0.
- Capture at accept: op, addr, wdata and flags are registered. Input changes after accept are ignored.
- States: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - error -> RESP
  - load -> RD
  - word store -> WR
  - byte/half store -> RD
- Transitions from other states:
  - RD -> RESP (load) or WR (sub-word store)
  - WR -> RESP
  - RESP -> IDLE
- Latency, in cycles from the accept edge to resp_valid high:
  - load: 2
  - word store: 2
  - sub-word store: 3
  - error: 1
  - One request completes every latency+1 cycles. No pipelining.
- Memory outputs are decoded from registered state/regs only; there is no combinational path from req_* to mem_*.
  - mem_read=1 only in RD.
  - mem_write=1 only in WR.
  - Never both high.
  - mem_address is held stable through RD and WR.
- RD: DM updates data_read on the negedge inside RD. The unit captures mem_data_read at the posedge that ends RD.
- Load extraction, byte lane off = addr[1:0]:
  - byte: lane = word[31-8*off -: 8]
  - half: off 0 -> [31:16], off 2 -> [15:0]
  - The lane is extended per req_unsigned. Word loads return the word unchanged.
- Store merge in WR:
  - Byte: the captured word with lane off replaced by wdata[7:0].
  - Half: the half at off replaced by wdata[15:0].
  - Word: wdata unchanged.
- Errors:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - req_size=11.
  - addr + bytes - 1 >= MEM_DEPTH, computed without 32-bit wrap.
  - On error: mem_read and mem_write stay low for the whole request, resp_err=1, resp_rdata=0.
- resp_rdata and resp_err hold their value until the next RESP.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous), so mem_write drops before the next posedge and no partial write occurs. The pending request is dropped with no response.

Test Plan:
1. DM word 0x10 = 0x8899AABB. LW 0x10 -> resp_valid 2 cycles after accept; rdata 0x8899AABB; err=0; mem_read high exactly 1 cycle.
2. LB 0x11 -> 0xFFFFFF99. LBU 0x11 -> 0x00000099. LH 0x12 -> 0xFFFFAABB. LHU 0x10 -> 0x00008899.
3. SB 0x12 with wdata 0x000000CC -> RD then WR; mem_data_write=0x8899CCBB; resp after 3 cycles; a following LW 0x10 returns 0x8899CCBB. SH 0x10 with 0x1234 -> word becomes 0x1234CCBB.
4. LW 0x13, SH 0x11, size=11 and LW 0x400 (MEM_DEPTH=1024) -> each gives err=1, rdata=0, resp after 1 cycle, mem_read/mem_write never high. LW 0x3FC succeeds.
5. Back-to-back requests with req_valid held high -> req_ready low from accept through RESP; no request lost or duplicated. Changing req_addr after accept does not affect the access.
6. Assert rst_n=0 mid-WR of SW 0x20 with 0xDEADBEEF, before the posedge -> mem_write low immediately; DM word 0x20 unchanged; no resp_valid; req_ready=1 after release.
